// File: rtl/pipe_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_fetch_ctrl
//
// Instruction-fetch controller for a simple in-order pipeline. It owns the
// fetch PC, issues one request at a time to instruction memory, captures the
// returned word and holds it until the IF/ID stage accepts it. On acceptance
// the next PC is chosen from pc+4 or one of three redirect targets.
//
// Sequence per instruction: FETCH (wait for imem_ack) -> VALID (wait for
// wpcir) -> FETCH ... Best case is one instruction every two cycles.
//
// Parameters
//   RESET_PC     PC loaded on reset (bits [1:0] are cleared).
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset, overrides every other input
//   pcsource     next-PC select: 0 pc+4, 1 bpc, 2 rpc, 3 jpc
//   bpc/rpc/jpc  branch / register-jump / jump targets
//   wpcir        downstream accept; IF/ID takes inst this cycle
//   imem_ack     imem_rdata is valid this cycle (only honoured in FETCH)
//   imem_rdata   instruction word from memory
//   imem_req     fetch request, high for the whole FETCH state
//   imem_addr    fetch address, always equal to pc
//   pc           current fetch PC (registered, word aligned)
//   pc4          pc + 4, modulo 2^32 (combinational)
//   inst         last captured instruction (registered)
//   inst_valid   inst holds a fetched, not yet consumed instruction
//   stall_cnt    only when FETCH_STALL_COUNT_EN is defined: free-running
//                count of cycles spent waiting for imem_ack or for wpcir
//
// Configuration
//   FETCH_STALL_COUNT_EN  define to add the stall_cnt output and its counter.
// -----------------------------------------------------------------------------
module pipe_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        inst_valid
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] npc;
  logic        take_inst;  // memory answered the outstanding request
  logic        advance;    // IF/ID consumed inst, move to the next PC

  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;

  assign take_inst = (state_q == FETCH) && imem_ack;
  assign advance   = (state_q == VALID) && wpcir;

  // Next-PC select. Only consumed in the advance cycle, so changes to
  // pcsource or the targets during FETCH cannot disturb the in-flight address.
  always_comb begin
    case (pcsource)
      2'd0:    npc = pc4;
      2'd1:    npc = bpc;
      2'd2:    npc = rpc;
      default: npc = jpc;
    endcase
  end

  // Next-state and request decode.
  always_comb begin
    // NOTE: every output of this block gets a value before the case, so no
    // path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = VALID;
      end
      VALID: if (wpcir) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // State register and fetch datapath.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= IDLE;
      pc         <= {RESET_PC[31:2], 2'b00};
      inst       <= 32'h0;
      inst_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_inst) begin
        inst       <= imem_rdata;
        inst_valid <= 1'b1;
      end
      if (advance) begin
        // Targets may be misaligned; the PC is always word aligned.
        pc         <= {npc[31:2], 2'b00};
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  // Counts cycles lost waiting on memory or on the downstream stage.
  // Wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'h0;
    end else if (((state_q == FETCH) && !imem_ack) ||
                 ((state_q == VALID) && !wpcir)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
